// File: rtl/key_direction_encoder.sv
// key_direction_encoder
//   Turns USB HID keyboard reports into a WASD held-key set and a one-byte
//   direction code for the ball stage. The direction code is refreshed once
//   per video frame (frame_clk rising edge, synchronized into Clk). The held
//   set is dropped after STALE_CYCLES Clk cycles without a report.
//
// Ports
//   Clk                   system clock, all state on its rising edge
//   Reset                 asynchronous, active-low
//   keycode0..keycode3    key slots of the current HID report
//   report_valid          one-cycle strobe qualifying keycode0..3
//   frame_clk             VGA vsync, asynchronous to Clk
//   keycode   [7:0]       registered direction code, updated per frame
//   held      [3:0]       registered held set {W,A,S,D}
//   stale                 high while the held set has been cleared by timeout

// Per-slot decoder: one-hot WASD match plus rollover (0x01) flag.
module kde_slot_dec (
  input  logic [7:0] code,
  output logic [3:0] hit,       // {W,A,S,D}
  output logic       rollover
);
  always_comb begin
    hit      = {code == 8'h1A, code == 8'h04, code == 8'h16, code == 8'h07};
    rollover = (code == 8'h01);
  end
endmodule

module key_direction_encoder #(
  parameter int unsigned STALE_CYCLES = 50_000_000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  input  logic [7:0] keycode2,
  input  logic [7:0] keycode3,
  input  logic       report_valid,
  input  logic       frame_clk,
  output logic [7:0] keycode,
  output logic [3:0] held,
  output logic       stale
);
  localparam int NUM_SLOTS = 4;
  localparam int CNT_W     = (STALE_CYCLES < 1) ? 1 : $clog2(STALE_CYCLES + 1);
  localparam logic [CNT_W-1:0] STALE_MAX = CNT_W'(STALE_CYCLES);

  // Report decode
  logic [NUM_SLOTS-1:0][7:0] slot;
  logic [NUM_SLOTS-1:0][3:0] slot_hit;
  logic [NUM_SLOTS-1:0]      slot_roll;
  logic [3:0]                rpt_set;
  logic                      rpt_roll;

  assign slot = {keycode3, keycode2, keycode1, keycode0};

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    kde_slot_dec u_dec (
      .code     (slot[i]),
      .hit      (slot_hit[i]),
      .rollover (slot_roll[i])
    );
  end

  always_comb begin
    rpt_set  = '0;
    rpt_roll = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      rpt_set  = rpt_set | slot_hit[i];
      rpt_roll = rpt_roll | slot_roll[i];
    end
  end

  // Direction resolve/encode from the registered held set. Opposing keys
  // cancel on their axis.
  logic       v_up, v_dn, h_lt, h_rt;
  logic [7:0] dir_code;

  always_comb begin
    v_up = held[3] & ~held[1];
    v_dn = held[1] & ~held[3];
    h_lt = held[2] & ~held[0];
    h_rt = held[0] & ~held[2];
    case ({v_up, v_dn, h_lt, h_rt})
      4'b1001: dir_code = 8'h01;
      4'b1010: dir_code = 8'h02;
      4'b0101: dir_code = 8'h03;
      4'b0110: dir_code = 8'h04;
      4'b0010: dir_code = 8'h05;
      4'b0001: dir_code = 8'h07;
      4'b0100: dir_code = 8'h16;
      4'b1000: dir_code = 8'h1A;
      default: dir_code = 8'h00;
    endcase
  end

  // frame_clk synchronizer and rising-edge detect
  logic f1, f2, f3;
  logic frame_pulse;
  assign frame_pulse = f2 & ~f3;

  // Timeout counter: saturates at STALE_MAX so expiry fires only once.
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             cnt_sat, expire;

  always_comb begin
    cnt_sat = (cnt == STALE_MAX);
    if (report_valid)  cnt_nxt = '0;
    else if (cnt_sat)  cnt_nxt = cnt;
    else               cnt_nxt = cnt + 1'b1;
    expire = ~report_valid & ~cnt_sat & (cnt_nxt == STALE_MAX);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      f1      <= 1'b0;
      f2      <= 1'b0;
      f3      <= 1'b0;
      cnt     <= '0;
      keycode <= 8'h00;
      held    <= 4'b0000;
      stale   <= 1'b0;
    end else begin
      f1  <= frame_clk;
      f2  <= f1;
      f3  <= f2;
      cnt <= cnt_nxt;
      // Uses the pre-update held set when a report lands on the same edge.
      if (frame_pulse) keycode <= dir_code;
      if (report_valid) begin
        stale <= 1'b0;
        if (!rpt_roll) held <= rpt_set;
      end else if (expire) begin
        held  <= 4'b0000;
        stale <= 1'b1;
      end
    end
  end
endmodule

// File: doc/key_direction_encoder.md
KEY_DIRECTION_ENCODER -- requirements
Module: key_direction_encoder

Interface
REQ-001 The block SHALL have the parameter STALE_CYCLES, default 50_000_000, giving the number of Clk cycles without report_valid before the held-key set is cleared.
REQ-002 The block SHALL have the port Clk  input  1  system clock (50 MHz), all state on its rising edge.
REQ-003 The block SHALL have the port Reset  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have the ports keycode0..keycode3  input  8 each  key slots of one USB HID keyboard report.
REQ-005 The block SHALL have the port report_valid  input  1  one-Clk pulse marking keycode0..3 as a new report.
REQ-006 The block SHALL have the port frame_clk  input  1  VGA vertical sync, asynchronous to Clk.
REQ-007 The block SHALL have the port keycode  output  8  registered direction code consumed by the ball stage.
REQ-008 The block SHALL have the port held  output  4  registered held-key set {W,A,S,D}, with bit 3 being W.
REQ-009 The block SHALL have the port stale  output  1  high while the held set is cleared by timeout.

Function
REQ-010 HID codes SHALL be W=0x1A, A=0x04, S=0x16, D=0x07; all other codes are ignored.
REQ-011 On a report_valid cycle whose slots contain no 0x01, the held set SHALL become, at the next edge, exactly the set of WASD codes present in any slot; duplicates are harmless.
REQ-012 A report containing 0x01 (rollover) in any slot SHALL leave the held set unchanged but still restart the timeout.
REQ-013 The held set SHALL be resolved combinationally: W and S together give vertical none; A and D together give horizontal none.
REQ-014 The resolved direction SHALL be encoded as up+right=0x01, up+left=0x02, down+right=0x03, down+left=0x04, left=0x05, right=0x07, down=0x16, up=0x1A, none=0x00.
REQ-015 frame_clk SHALL pass through a 3-stage synchronizer (f1,f2,f3); frame_pulse = f2 & ~f3.
REQ-016 keycode SHALL load the encoded value of the registered held set on the Clk edge where frame_pulse is high, and hold otherwise; latency is 3 Clk edges from the frame_clk rise.
REQ-017 If report_valid and frame_pulse coincide, keycode SHALL take the encoding of the pre-update held set; the new set is used at the next frame.
REQ-018 The timeout counter SHALL be ceil(log2(STALE_CYCLES+1)) bits wide.
REQ-019 The timeout counter SHALL clear on report_valid and otherwise increment, saturating at STALE_CYCLES.
REQ-020 On the edge where the counter reaches STALE_CYCLES, held SHALL clear and stale SHALL set.
REQ-021 The next report_valid SHALL clear stale and load the held set per REQ-011/012; on a rollover report, held stays 0.
REQ-022 held and stale SHALL update at most once per Clk edge; no output is combinational.

Reset
REQ-023 While Reset=0, keycode SHALL be 0x00, held 4'b0000, stale 0, the counter 0, and f1..f3 0, independent of Clk.
REQ-024 The release of Reset SHALL take effect at the next Clk edge; a frame_clk already high at release SHALL produce one frame_pulse 3 edges later.
REQ-025 Reset asserted mid-operation SHALL discard any pending report or frame edge.

Verification
REQ-026 The bench SHALL cover: report {0x1A,0x07,0,0} then a frame_clk rise -> held=4'b1001, keycode=0x01 exactly 3 Clk edges after the rise.
REQ-027 The bench SHALL cover: report {0x1A,0x16,0x04,0} then a frame -> keycode=0x05; report {0x04,0x07,0,0} then a frame -> keycode=0x00.
REQ-028 The bench SHALL cover: report {0x16,0,0,0} coinciding with frame_pulse while held=W -> keycode=0x1A that frame and 0x16 the next frame.
REQ-029 The bench SHALL cover: report {0x01,0x01,0x01,0x01} while held=A -> held unchanged and keycode stays 0x05 on following frames.
REQ-030 The bench SHALL cover: STALE_CYCLES=100 with held=D and no reports -> stale=1 and held=0 at cycle 100, keycode=0x00 after the next frame, and a new report {0x07,0,0,0} -> stale=0.
REQ-031 The bench SHALL cover: Reset=0 asserted between Clk edges while keycode=0x03 -> keycode=0x00 and held=0 immediately.
